equiv_mismatch_monitor: RTL

EQUIV_MISMATCH_MONITOR -- requirements
Module: equiv_mismatch_monitor

---
 rtl/equiv_pkg.sv | 20 ++
 rtl/equiv_rec_fifo.sv | 57 +++++
 rtl/equiv_mismatch_monitor.sv | 131 +++++++++++++
 3 files changed

// File: rtl/equiv_pkg.sv
// rtl/equiv_pkg.sv - shared types and constants for the equivalence mismatch monitor
package equiv_pkg;

    // Monitor phases: ignore start-up noise, compare, or stop after first failure
    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALT   = 2'd2
    } mon_state_e;

    localparam int DEF_WIDTH = 91;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_REC_W = DEF_CNT_W + DEF_WIDTH;

    // A record is {cycle stamp, y_1 ^ y_2}
    function automatic int rec_width(input int cnt_w, input int width);
        return cnt_w + width;
    endfunction

endpackage

// File: rtl/equiv_rec_fifo.sv
// rtl/equiv_rec_fifo.sv - synchronous record FIFO with full/empty flags
module equiv_rec_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic         do_pop;
    logic         do_push;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    // A pop frees the head slot at the same edge, so a push into a full FIFO is still accepted
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head reads as zero when nothing is stored so the output is clean after reset
    assign head_data = empty ? '0 : mem[rd_q[AW-1:0]];

    // Record storage; contents are qualified by the pointers so no reset is needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q[AW-1:0]] <= push_data;
        end
    end

    // Read/write pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/equiv_mismatch_monitor.sv
// rtl/equiv_mismatch_monitor.sv - compares two design copies and queues mismatch records
module equiv_mismatch_monitor
    import equiv_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int DEPTH         = 4,
    parameter int STOP_ON_FAIL  = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic [WIDTH-1:0]                     y_1,
    input  logic [WIDTH-1:0]                     y_2,
    output logic                                 fail,
    output logic [CNT_W-1:0]                     mismatch_cnt,
    output logic [CNT_W-1:0]                     cycle_cnt,
    output logic [CNT_W-1:0]                     drop_cnt,
    output logic                                 rpt_valid,
    input  logic                                 rpt_ready,
    output logic [rec_width(CNT_W, WIDTH)-1:0]   rpt_data
);

    localparam int REC_W = rec_width(CNT_W, WIDTH);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 2);
    // With no settle period the monitor starts comparing straight out of reset
    localparam mon_state_e RESET_STATE = (SETTLE_CYCLES == 0) ? ST_RUN : ST_SETTLE;

    mon_state_e        state_q;
    mon_state_e        state_d;
    logic [SET_W-1:0]  settle_q;
    logic [SET_W-1:0]  settle_d;
    logic              compare;
    logic              mismatch;
    logic              push;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WIDTH-1:0]  diff;
    logic [REC_W-1:0]  rec;

    assign diff     = y_1 ^ y_2;
    assign mismatch = (y_1 != y_2);
    assign push     = compare && mismatch;
    assign pop      = rpt_valid && rpt_ready;
    assign drop     = push && fifo_full && !pop;
    assign rec      = {cycle_cnt, diff};
    assign rpt_valid = !fifo_empty;

    // Next-state: count enabled settle cycles, compare in RUN, optionally halt on first mismatch
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        compare  = 1'b0;
        case (state_q)
            ST_SETTLE: begin
                if (enable) begin
                    settle_d = settle_q + 1'b1;
                    if (settle_d == SET_W'(SETTLE_CYCLES)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (enable) begin
                    compare = 1'b1;
                    if (mismatch && (STOP_ON_FAIL != 0)) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // State and settle progress register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RESET_STATE;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    // Sticky fail flag and saturating statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            fail         <= 1'b0;
            mismatch_cnt <= '0;
            cycle_cnt    <= '0;
            drop_cnt     <= '0;
        end else begin
            if (compare && (cycle_cnt != '1)) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
            if (push) begin
                fail <= 1'b1;
            end
            if (push && (mismatch_cnt != '1)) begin
                mismatch_cnt <= mismatch_cnt + 1'b1;
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    equiv_rec_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_rec_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (rec),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (rpt_data)
    );

endmodule
